// File: rtl/bitstream_pkg.sv
// Shared constants and state encoding for the bit packer / unpacker pair.
package bitstream_pkg;
  localparam int IN_W  = 256;
  localparam int WIN_W = 32;
  localparam int LEN_W = 6;
  localparam int CNT_W = 10;
  localparam int BUF_W = 2 * IN_W;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } bs_state_e;
endpackage

// File: rtl/bit_unpack_256bits_if.sv
// Stream-in / peek-window / consume bus of the bit-stream reader.
interface bit_unpack_256bits_if;
  import bitstream_pkg::*;

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIN_W-1:0] win_data;
  logic [LEN_W-1:0] win_bits;
  logic             win_valid;
  logic             consume_en;
  logic [LEN_W-1:0] consume_len;
  logic             align_en;
  logic             done;
  logic             err;

  modport slave (
    input  in_data, in_valid, in_last, consume_en, consume_len, align_en,
    output in_ready, win_data, win_bits, win_valid, done, err
  );

  modport master (
    output in_data, in_valid, in_last, consume_en, consume_len, align_en,
    input  in_ready, win_data, win_bits, win_valid, done, err
  );
endinterface

// File: rtl/bit_buf_shifter.sv
// Drops d bits off the bottom of the buffer and merges a new word just above
// the surviving bits.
module bit_buf_shifter
  import bitstream_pkg::*;
(
  input  logic [BUF_W-1:0] buf_q,
  input  logic [LEN_W-1:0] d,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  input  logic [IN_W-1:0]  in_data,
  output logic [BUF_W-1:0] buf_nxt
);
  logic [CNT_W-1:0] ofs;
  logic [BUF_W-1:0] ins;

  // Loads only happen with cnt <= IN_W, so the word always fits in BUF_W.
  assign ofs     = cnt - CNT_W'(d);
  assign ins     = load ? ({{IN_W{1'b0}}, in_data} << ofs) : '0;
  assign buf_nxt = (buf_q >> d) | ins;
endmodule

// File: rtl/bit_unpack_256bits.sv
// LSB-first bit-stream reader: 256-bit words in, 32-bit peek window out,
// variable-length consume and byte alignment.
module bit_unpack_256bits
  import bitstream_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  bit_unpack_256bits_if.slave  bus
);
  logic [BUF_W-1:0] buf_q, buf_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       pos_q, pos_nxt, need;
  logic             eos_q, eos_nxt, err_q;
  bs_state_e        st_q;

  logic             active, load, illegal, win_valid_c;
  logic [LEN_W-1:0] win_bits_c, align_d, d;
  logic [WIN_W-1:0] win_mask;

  assign active      = (st_q != ST_DONE);
  assign win_bits_c  = (cnt_q >= CNT_W'(WIN_W)) ? LEN_W'(WIN_W) : LEN_W'(cnt_q);
  assign win_valid_c = (cnt_q >= CNT_W'(WIN_W)) || (eos_q && (cnt_q != '0));
  // 1<<32 wraps to 0 in WIN_W bits, so a full window yields an all-ones mask.
  assign win_mask    = (WIN_W'(1) << win_bits_c) - WIN_W'(1);

  assign bus.in_ready  = (cnt_q <= CNT_W'(IN_W)) && !eos_q;
  assign bus.win_data  = buf_q[WIN_W-1:0] & win_mask;
  assign bus.win_bits  = win_bits_c;
  assign bus.win_valid = win_valid_c;
  assign bus.done      = (st_q == ST_DONE);
  assign bus.err       = err_q;

  assign load    = active && bus.in_valid && bus.in_ready;
  assign illegal = active && bus.consume_en &&
                   ((bus.consume_len > win_bits_c) ||
                    (bus.consume_len > LEN_W'(WIN_W)) || !win_valid_c);

  // Bits to the next byte boundary, clipped to what is buffered.
  assign need    = 3'(4'd8 - {1'b0, pos_q});
  assign align_d = (cnt_q < CNT_W'(need)) ? LEN_W'(cnt_q) : LEN_W'(need);

  always_comb begin
    d = '0;
    if (active) begin
      if (bus.consume_en) d = illegal ? '0 : bus.consume_len;
      else if (bus.align_en) d = align_d;
    end
  end

  assign cnt_nxt = cnt_q - CNT_W'(d) + (load ? CNT_W'(IN_W) : '0);
  assign pos_nxt = pos_q + d[2:0];
  assign eos_nxt = eos_q | (load & bus.in_last);

  bit_buf_shifter u_shift (
    .buf_q   (buf_q),
    .d       (d),
    .cnt     (cnt_q),
    .load    (load),
    .in_data (bus.in_data),
    .buf_nxt (buf_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      pos_q <= '0;
      eos_q <= 1'b0;
      err_q <= 1'b0;
      st_q  <= ST_FILL;
    end else if (active) begin
      buf_q <= buf_nxt;
      cnt_q <= cnt_nxt;
      pos_q <= pos_nxt;
      eos_q <= eos_nxt;
      if (illegal) err_q <= 1'b1;
      if (eos_nxt && (cnt_nxt == '0))      st_q <= ST_DONE;
      else if (eos_nxt)                    st_q <= ST_DRAIN;
      else if (cnt_nxt >= CNT_W'(WIN_W))   st_q <= ST_STREAM;
      else                                 st_q <= ST_FILL;
    end
  end
endmodule
